// File: rtl/cache_bus_pkg.sv
// Shared definitions for the C1/A1/D1 cache bus: command codes, bus widths,
// cache address split, master state enum and request/response helpers.
package cache_bus_pkg;

  localparam int ADDR_W  = 19;
  localparam int ADDR1_W = 15;
  localparam int DATA_W  = 16;
  localparam int CTR1_W  = 3;
  localparam int TAG_W   = 10;
  localparam int SET_W   = 5;
  localparam int OFFS_W  = 4;

  localparam logic [CTR1_W-1:0] C1_NOP        = 3'd0;
  localparam logic [CTR1_W-1:0] C1_READ8      = 3'd1;
  localparam logic [CTR1_W-1:0] C1_READ16     = 3'd2;
  localparam logic [CTR1_W-1:0] C1_READ32     = 3'd3;
  localparam logic [CTR1_W-1:0] C1_WRITE8     = 3'd4;
  localparam logic [CTR1_W-1:0] C1_WRITE16    = 3'd5;
  localparam logic [CTR1_W-1:0] C1_WRITE32    = 3'd6;
  localparam logic [CTR1_W-1:0] C1_INVALIDATE = 3'd7;
  // The cache answers with code 7 while the master has C1 released, so it
  // can share the encoding with INVALIDATE; direction tells them apart.
  localparam logic [CTR1_W-1:0] C1_RESPONSE   = 3'd7;

  localparam logic [1:0] C2_NOP      = 2'd0;
  localparam logic [1:0] C2_READ     = 2'd1;
  localparam logic [1:0] C2_WRITE    = 2'd2;
  localparam logic [1:0] C2_RESPONSE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_OFFS, ST_WAIT, ST_RD2, ST_RESP
  } c1_state_e;

  typedef struct packed {
    logic [CTR1_W-1:0] cmd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } c1_req_t;

  function automatic logic is_write(input logic [CTR1_W-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic [DATA_W-1:0] wr_low(input c1_req_t r);
    if (r.cmd == C1_WRITE8)  return {8'h00, r.wdata[7:0]};
    if (is_write(r.cmd))     return r.wdata[15:0];
    return '0;
  endfunction

  function automatic logic [31:0] rd_mask(input logic [CTR1_W-1:0] cmd,
                                          input logic [31:0] d);
    case (cmd)
      C1_READ8:  return {24'h0, d[7:0]};
      C1_READ16: return {16'h0, d[15:0]};
      C1_READ32: return d;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: when both request, the one that was not granted
// last wins; a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = valid;
    if (valid == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/c1_bus_master.sv
// CPU-side C1/A1/D1 bus master: arbitrates two requesters, runs the two-tick
// command/address/data phase, waits for C1_RESPONSE and returns tagged data.
// Define C1_BUS_MASTER_TIMEOUT_EN to bound WAIT with an error response.
module c1_bus_master
  import cache_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][CTR1_W-1:0] req_cmd,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][31:0]       req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [CTR1_W-1:0]      c1_out,
  output logic                   c1_oe,
  input  logic [CTR1_W-1:0]      c1_in,
  output logic [ADDR1_W-1:0]     a1_out,
  output logic                   a1_oe,
  output logic [DATA_W-1:0]      d1_out,
  output logic                   d1_oe,
  input  logic [DATA_W-1:0]      d1_in
);

  c1_state_e   state_q, state_d;
  c1_req_t     req_q, req_d;
  logic        last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  gnt;

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (last_q),
    .gnt   (gnt)
  );

`ifdef C1_BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    last_d  = last_q;
    data_d  = data_q;
`ifdef C1_BUS_MASTER_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          req_d.cmd   = req_cmd[gnt[1]];
          req_d.addr  = req_addr[gnt[1]];
          req_d.wdata = req_wdata[gnt[1]];
          last_d      = gnt[1];
          data_d      = '0;
`ifdef C1_BUS_MASTER_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = (req_cmd[gnt[1]] == C1_NOP) ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_OFFS;
      ST_OFFS: state_d = ST_WAIT;
      ST_WAIT: begin
        if (c1_in == C1_RESPONSE) begin
          data_d[15:0] = d1_in;
          state_d      = (req_q.cmd == C1_READ32) ? ST_RD2 : ST_RESP;
        end
`ifdef C1_BUS_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RD2: begin
        data_d[31:16] = d1_in;
        state_d       = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef C1_BUS_MASTER_TIMEOUT_EN
  // Counts completed WAIT cycles; anything leaving WAIT clears it.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT && state_d == ST_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Bus drives decode straight from state so reset releases A1/D1 at once.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    c1_oe     = 1'b1;
    c1_out    = C1_NOP;
    a1_oe     = 1'b0;
    a1_out    = '0;
    d1_oe     = 1'b0;
    d1_out    = '0;
    case (state_q)
      ST_IDLE: if (!reset) req_ready = gnt;
      ST_ADDR: begin
        c1_out = req_q.cmd;
        a1_oe  = 1'b1;
        a1_out = req_q.addr[ADDR_W-1:OFFS_W];
        d1_oe  = 1'b1;
        d1_out = wr_low(req_q);
      end
      ST_OFFS: begin
        c1_out = req_q.cmd;
        a1_oe  = 1'b1;
        a1_out = {{(ADDR1_W-OFFS_W){1'b0}}, req_q.addr[OFFS_W-1:0]};
        d1_oe  = is_write(req_q.cmd);
        d1_out = (req_q.cmd == C1_WRITE32) ? req_q.wdata[31:16] : wr_low(req_q);
      end
      ST_WAIT, ST_RD2: c1_oe = 1'b0;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = last_q;  // last is loaded with the winner on grant
        rsp_data  = rd_mask(req_q.cmd, data_q);
`ifdef C1_BUS_MASTER_TIMEOUT_EN
        rsp_err   = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_c1_bus_master.sv
// Randomized self-checking bench for c1_bus_master with a transaction-level
// model of arbitration, bus phases and response data.
module tb_c1_bus_master;

  localparam logic [2:0] NOP = 3'd0, RD8 = 3'd1, RD16 = 3'd2, RD32 = 3'd3;
  localparam logic [2:0] WR8 = 3'd4, WR16 = 3'd5, WR32 = 3'd6, RSPC = 3'd7;
`ifdef C1_BUS_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_cmd;
  logic [1:0][18:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic             rsp_valid, rsp_id, rsp_err;
  logic [31:0]      rsp_data;
  logic [2:0]       c1_out, c1_in;
  logic             c1_oe, a1_oe, d1_oe;
  logic [14:0]      a1_out;
  logic [15:0]      d1_out, d1_in;

  int nvec = 0;
  int nerr = 0;
  bit model_last = 1'b1;

  c1_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .c1_out(c1_out), .c1_oe(c1_oe), .c1_in(c1_in),
    .a1_out(a1_out), .a1_oe(a1_oe),
    .d1_out(d1_out), .d1_oe(d1_oe), .d1_in(d1_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rsp(input logic [2:0] cmd,
                                            input logic [15:0] lo, hi);
    case (cmd)
      RD8:     return 32'(lo) & 32'hFF;
      RD16:    return 32'(lo);
      RD32:    return {hi, lo};
      default: return 32'h0;
    endcase
  endfunction

  // One full transaction from the IDLE cycle through the RESP cycle.
  task automatic run_txn(input logic [1:0] vmask, input int rdly,
                         input logic [15:0] dlo, dhi, input bit tmo);
    int g;
    logic [2:0] cmd;
    logic [18:0] addr;
    logic [31:0] wd, er;
    logic [15:0] dexp, doffs;
    logic [1:0] rdy;
    bit wr;
    g    = (vmask == 2'b11) ? (model_last ? 0 : 1) : (vmask[1] ? 1 : 0);
    cmd  = req_cmd[g];
    addr = req_addr[g];
    wd   = req_wdata[g];
    wr   = (cmd == WR8) || (cmd == WR16) || (cmd == WR32);
    dexp = (cmd == WR8) ? {8'h00, wd[7:0]} : (wr ? wd[15:0] : 16'h0);
    doffs = (cmd == WR32) ? wd[31:16] : dexp;
    rdy  = (g == 1) ? 2'b10 : 2'b01;

    @(negedge clk); req_valid = vmask; c1_in = RSPC; d1_in = 16'($urandom); #1;
    nvec++;
    if (req_ready !== rdy) begin
      nerr++; $display("FAIL grant: got %b want %b", req_ready, rdy);
    end
    nvec++;
    if ({c1_oe, c1_out, a1_oe, d1_oe, rsp_valid} !== {1'b1, NOP, 3'b000}) begin
      nerr++; $display("FAIL idle_bus: got %b", {c1_oe, c1_out, a1_oe, d1_oe, rsp_valid});
    end
    model_last = g[0];

    if (cmd != NOP) begin
      @(negedge clk); #1;
      nvec++;
      if ({c1_oe, c1_out, a1_oe, a1_out, d1_oe, rsp_valid, req_ready} !==
          {1'b1, cmd, 1'b1, addr[18:4], 1'b1, 1'b0, 2'b00}) begin
        nerr++; $display("FAIL addr_phase: got c1=%h a1=%h oe=%b%b%b want c1=%h a1=%h",
                         c1_out, a1_out, c1_oe, a1_oe, d1_oe, cmd, addr[18:4]);
      end
      if (wr) begin
        nvec++;
        if (d1_out !== dexp) begin
          nerr++; $display("FAIL addr_d1: got %h want %h", d1_out, dexp);
        end
      end
      @(negedge clk); #1;
      nvec++;
      if ({c1_oe, c1_out, a1_oe, a1_out, d1_oe, rsp_valid} !==
          {1'b1, cmd, 1'b1, {11'b0, addr[3:0]}, wr, 1'b0}) begin
        nerr++; $display("FAIL offs_phase: got c1=%h a1=%h d1_oe=%b want c1=%h a1=%h d1_oe=%b",
                         c1_out, a1_out, d1_oe, cmd, {11'b0, addr[3:0]}, wr);
      end
      if (wr) begin
        nvec++;
        if (d1_out !== doffs) begin
          nerr++; $display("FAIL offs_d1: got %h want %h", d1_out, doffs);
        end
      end
      for (int k = 1; k <= rdly; k++) begin
        @(negedge clk);
        c1_in = (k == rdly && !tmo) ? RSPC : 3'($urandom_range(0, 6));
        d1_in = (k == rdly) ? dlo : 16'($urandom);
        #1;
        nvec++;
        if ({c1_oe, a1_oe, d1_oe, rsp_valid, req_ready} !== 6'b0) begin
          nerr++; $display("FAIL wait_release: cycle %0d got %b want 000000", k,
                           {c1_oe, a1_oe, d1_oe, rsp_valid, req_ready});
        end
      end
      if (cmd == RD32 && !tmo) begin
        @(negedge clk); c1_in = 3'($urandom_range(0, 6)); d1_in = dhi; #1;
        nvec++;
        if ({c1_oe, a1_oe, d1_oe, rsp_valid} !== 4'b0) begin
          nerr++; $display("FAIL rd2_release: got %b want 0000", {c1_oe, a1_oe, d1_oe, rsp_valid});
        end
      end
    end

    @(negedge clk); c1_in = RSPC; d1_in = 16'($urandom); #1;
    er = tmo ? 32'h0 : model_rsp(cmd, dlo, dhi);
    nvec++;
    if ({rsp_valid, rsp_id, rsp_err} !== {1'b1, g[0], tmo}) begin
      nerr++; $display("FAIL rsp_flags: got v/id/err=%b%b%b want 1%b%b",
                       rsp_valid, rsp_id, rsp_err, g[0], tmo);
    end
    nvec++;
    if (rsp_data !== er) begin
      nerr++; $display("FAIL rsp_data: cmd %0d got %h want %h", cmd, rsp_data, er);
    end
    nvec++;
    if ({c1_oe, c1_out, a1_oe, d1_oe, req_ready} !== {1'b1, NOP, 4'b0000}) begin
      nerr++; $display("FAIL resp_bus: got %b", {c1_oe, c1_out, a1_oe, d1_oe, req_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; c1_in = RSPC; d1_in = 16'h0;
    req_cmd = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk); #1;
    nvec++;
    if ({req_ready, rsp_valid, rsp_err, rsp_data, c1_oe, c1_out, a1_oe, d1_oe} !==
        {2'b00, 1'b0, 1'b0, 32'h0, 1'b1, NOP, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL reset_state: rdy=%b v=%b err=%b data=%h c1=%b/%h a1_oe=%b d1_oe=%b",
                       req_ready, rsp_valid, rsp_err, rsp_data, c1_oe, c1_out, a1_oe, d1_oe);
    end
    @(negedge clk); req_valid = 2'b00; reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_read32();
    req_cmd[0] = RD32; req_addr[0] = 19'h00539; req_wdata[0] = 32'h0;
    run_txn(2'b01, 5, 16'hBEEF, 16'hDEAD, 1'b0);
  endtask

  task automatic test_write32();
    req_cmd[1] = WR32; req_addr[1] = 19'($urandom); req_wdata[1] = 32'h12345678;
    run_txn(2'b10, 3, 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      req_cmd[i] = RD8; req_addr[i] = 19'h00008; req_wdata[i] = 32'($urandom);
    end
    for (int n = 0; n < 4; n++) run_txn(2'b11, 1 + n, 16'hABCD, 16'h0, 1'b0);
    req_valid = 2'b00;
  endtask

  task automatic test_reset_midwait();
    req_cmd[0] = RD16; req_addr[0] = 19'($urandom); req_wdata[0] = 32'h0;
    @(negedge clk); req_valid = 2'b01; c1_in = NOP; #1;
    nvec++;
    if (req_ready !== 2'b01) begin
      nerr++; $display("FAIL midwait_grant: got %b want 01", req_ready);
    end
    @(negedge clk); req_valid = 2'b00;
    for (int k = 0; k < 3; k++) @(negedge clk);
    reset = 1'b1; #1;
    nvec++;
    if ({rsp_valid, c1_oe, c1_out, a1_oe, d1_oe, req_ready} !== {1'b0, 1'b1, NOP, 4'b0000}) begin
      nerr++; $display("FAIL midwait_reset_bus: got %b want 0100 0000",
                       {rsp_valid, c1_oe, c1_out, a1_oe, d1_oe, req_ready});
    end
    @(negedge clk); reset = 1'b0; c1_in = RSPC; d1_in = 16'hFFFF;
    model_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (rsp_valid !== 1'b0) begin
        nerr++; $display("FAIL midwait_no_rsp: cycle %0d got %b want 0", k, rsp_valid);
      end
      @(negedge clk);
    end
    req_cmd[1] = WR16; req_addr[1] = 19'($urandom); req_wdata[1] = 32'($urandom);
    run_txn(2'b11, 2, 16'h0, 16'h0, 1'b0);
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        req_cmd[i]   = 3'($urandom_range(0, 7));
        req_addr[i]  = 19'($urandom);
        req_wdata[i] = $urandom;
      end
      run_txn(2'($urandom_range(1, 3)), $urandom_range(1, 6),
              16'($urandom), 16'($urandom), 1'b0);
    end
    req_valid = 2'b00;
  endtask

`ifdef C1_BUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    req_cmd[1] = RD32; req_addr[1] = 19'($urandom); req_wdata[1] = 32'h0;
    run_txn(2'b10, TO, 16'h0, 16'h0, 1'b1);
    req_valid = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_read32();
    test_write32();
    test_back_to_back();
    test_reset_midwait();
    test_random();
`ifdef C1_BUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
